// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame geometry, line levels and the serializer FSM state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  // Idle and stop share a level; the start bit is the opposite level.
  localparam logic UART_IDLE_LVL  = 1'b0;
  localparam logic UART_START_LVL = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Bus-side byte push port plus the serial line and status outputs of the
// UART transmitter.
interface uart_transmitter_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] TX_data;
  logic                      TX_valid;
  logic                      TX_ready;
  logic                      TX_bit;
  logic                      busy;
  logic                      fifo_full;
  logic                      fifo_empty;

  modport master (
    output TX_data,
    output TX_valid,
    input  TX_ready,
    input  TX_bit,
    input  busy,
    input  fifo_full,
    input  fifo_empty
  );

  modport slave (
    input  TX_data,
    input  TX_valid,
    output TX_ready,
    output TX_bit,
    output busy,
    output fifo_full,
    output fifo_empty
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Count-based byte FIFO with all DEPTH entries usable; pushes while full and
// pops while empty are ignored, so callers need not gate them.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] wdata_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]           head_q, head_d;
  logic [PtrW-1:0]           tail_q, tail_d;
  logic [CountW-1:0]         count_q, count_d;
  logic                      push_ok;
  logic                      pop_ok;

  assign full_o  = (count_q == CountW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[head_q];

  // A push is judged against the registered count, so a pop in the same
  // cycle does not make room for it.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) begin
      tail_d = tail_q + 1'b1;
    end
    if (pop_ok) begin
      head_d = head_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8-entry write FIFO feeding a 1-8-1 serializer, MSB first,
// start level 1 and idle/stop level 0, CLKS_PER_BIT clocks per bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input logic               CLK,
  input logic               RST,
  uart_transmitter_if.slave tx
);

  localparam int unsigned CountW   = $clog2(DEPTH) + 1;
  localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

  uart_state_e               state_q, state_d;
  logic [15:0]               baud_q, baud_d;
  logic [2:0]                bit_ctr_q, bit_ctr_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_bit_q, tx_bit_d;
  logic                      bit_end;

  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CountW-1:0]         fifo_count;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (tx.TX_valid),
    .wdata_i (tx.TX_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_ctr_d = bit_ctr_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;

    // Every state change happens at a bit-period end, which also clears the
    // baud counter, so each state is entered with the counter at zero.
    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d   = {shift_q[UART_DATA_BITS-2:0], 1'b0};
          bit_ctr_d = bit_ctr_q + 1'b1;
          if (bit_ctr_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          // Reload straight into START so back-to-back frames have no gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_bit_d = UART_IDLE_LVL;
    unique case (state_d)
      StStart: tx_bit_d = UART_START_LVL;
      StData:  tx_bit_d = shift_d[UART_DATA_BITS-1];
      default: tx_bit_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_ctr_q <= '0;
      shift_q   <= '0;
      tx_bit_q  <= UART_IDLE_LVL;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_ctr_q <= bit_ctr_d;
      shift_q   <= shift_d;
      tx_bit_q  <= tx_bit_d;
    end
  end

  assign tx.TX_bit     = tx_bit_q;
  assign tx.busy       = (state_q != StIdle);
  assign tx.fifo_full  = fifo_full;
  assign tx.fifo_empty = fifo_empty;
  assign tx.TX_ready   = !fifo_full;

  fifo_count_in_range: assert property (@(posedge CLK) disable iff (RST)
    fifo_count <= CountW'(DEPTH));

  no_pop_when_empty: assert property (@(posedge CLK) disable iff (RST)
    !(fifo_pop && fifo_empty));

endmodule

// File: tb/tb_uart_transmitter.sv
// Two transmitters (1 and 4 clocks per bit) share one push stream and are
// checked every cycle against a queue/frame-position model of the line.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int Depth = 8;
  localparam int NDut  = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  bit         chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  uart_transmitter_if tx1 ();
  uart_transmitter_if tx4 ();

  assign tx1.TX_data  = tx_data;
  assign tx1.TX_valid = tx_valid;
  assign tx4.TX_data  = tx_data;
  assign tx4.TX_valid = tx_valid;

  uart_transmitter #(.DEPTH(Depth), .CLKS_PER_BIT(1)) dut1 (.CLK(CLK), .RST(RST), .tx(tx1));
  uart_transmitter #(.DEPTH(Depth), .CLKS_PER_BIT(4)) dut4 (.CLK(CLK), .RST(RST), .tx(tx4));

  // Model: a byte queue per DUT plus the position inside the frame on the line
  // (-1 when idle). A new frame starts whenever the line is free and bytes wait.
  logic [7:0] mfifo [NDut][Depth];
  int         mhead [NDut];
  int         mcnt  [NDut];
  int         mpos  [NDut];
  logic [7:0] mcur  [NDut];

  function automatic int cpb_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NDut; k++) begin
      mhead[k] = 0;
      mcnt[k]  = 0;
      mpos[k]  = -1;
      mcur[k]  = 8'h00;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NDut; k++) begin
      int tail;
      int flen;
      bit push;
      tail = (mhead[k] + mcnt[k]) % Depth;
      push = tx_valid && (mcnt[k] < Depth);
      flen = int'(UART_FRAME_BITS) * cpb_of(k);
      if (mpos[k] >= 0 && mpos[k] < flen - 1) begin
        mpos[k]++;
      end else if (mcnt[k] > 0) begin
        mcur[k]  = mfifo[k][mhead[k]];
        mhead[k] = (mhead[k] + 1) % Depth;
        mcnt[k]--;
        mpos[k]  = 0;
      end else begin
        mpos[k] = -1;
      end
      if (push) begin
        mfifo[k][tail] = tx_data;
        mcnt[k]++;
      end
    end
  endtask

  function automatic logic exp_bit(int k);
    int idx;
    if (mpos[k] < 0) return UART_IDLE_LVL;
    idx = mpos[k] / cpb_of(k);
    if (idx == 0) return UART_START_LVL;
    if (idx == int'(UART_FRAME_BITS) - 1) return UART_IDLE_LVL;
    return mcur[k][int'(UART_DATA_BITS) - idx];
  endfunction

  initial begin
    model_clear();
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) model_clear();
      else     model_step();
    end
  end

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(string tag, int k, logic b, logic bsy, logic emp, logic ful,
                         logic rdy);
    chk({tag, "_TX_bit"},     80'(b),   80'(exp_bit(k)));
    chk({tag, "_busy"},       80'(bsy), 80'(mpos[k] >= 0));
    chk({tag, "_fifo_empty"}, 80'(emp), 80'(mcnt[k] == 0));
    chk({tag, "_fifo_full"},  80'(ful), 80'(mcnt[k] == Depth));
    chk({tag, "_TX_ready"},   80'(rdy), 80'(mcnt[k] != Depth));
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en && !RST) begin
        cmp_dut("dut1", 0, tx1.TX_bit, tx1.busy, tx1.fifo_empty, tx1.fifo_full, tx1.TX_ready);
        cmp_dut("dut4", 1, tx4.TX_bit, tx4.busy, tx4.fifo_empty, tx4.fifo_full, tx4.TX_ready);
      end
    end
  end

  task automatic wait_idle(int bound);
    int n;
    n = 0;
    while (!(tx1.busy === 1'b0 && tx4.busy === 1'b0 &&
             tx1.fifo_empty === 1'b1 && tx4.fifo_empty === 1'b1) && n < bound) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_within_bound", 80'(n < bound), 80'(1));
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_dut1_TX_bit"},     80'(tx1.TX_bit),     80'(0));
    chk({tag, "_dut1_busy"},       80'(tx1.busy),       80'(0));
    chk({tag, "_dut1_fifo_empty"}, 80'(tx1.fifo_empty), 80'(1));
    chk({tag, "_dut4_TX_bit"},     80'(tx4.TX_bit),     80'(0));
    chk({tag, "_dut4_busy"},       80'(tx4.busy),       80'(0));
    chk({tag, "_dut4_fifo_empty"}, 80'(tx4.fifo_empty), 80'(1));
  endtask

  initial begin
    logic [9:0]  got1;
    logic [79:0] got4;
    logic [79:0] exp4;
    logic [9:0]  f1;
    logic [9:0]  f2;
    int          busy_cnt;
    int          acc;
    int          pct;

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    chk("reset_dut1_full",  80'(tx1.fifo_full), 80'(0));
    chk("reset_dut1_ready", 80'(tx1.TX_ready),  80'(1));
    chk("reset_dut4_full",  80'(tx4.fifo_full), 80'(0));
    chk("reset_dut4_ready", 80'(tx4.TX_ready),  80'(1));
    RST    = 1'b0;
    chk_en = 1'b1;

    // Single byte 0xA5 at one clock per bit.
    @(negedge CLK); tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge CLK); tx_valid = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      got1[9-i] = tx1.TX_bit;
      if (tx1.busy) busy_cnt++;
    end
    chk("a5_frame", 80'(got1), 80'(10'b1101001010));
    chk("a5_busy_cycles", 80'(busy_cnt), 80'(10));
    @(negedge CLK);
    chk("a5_after_TX_bit", 80'(tx1.TX_bit), 80'(0));
    chk("a5_after_busy",   80'(tx1.busy),   80'(0));
    wait_idle(200);

    // 0x3C then 0xFF back to back at four clocks per bit.
    @(negedge CLK); tx_valid = 1'b1; tx_data = 8'h3C;
    @(negedge CLK); tx_data = 8'hFF;
    @(negedge CLK); tx_valid = 1'b0;
    f1 = 10'b1001111000;
    f2 = 10'b1111111110;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) @(negedge CLK);
      got4[79-i] = tx4.TX_bit;
      exp4[79-i] = (i < 40) ? f1[9 - i/4] : f2[9 - (i-40)/4];
      if (i == 39) chk("b2b_empty_before_pop2", 80'(tx4.fifo_empty), 80'(0));
      if (i == 40) chk("b2b_empty_after_pop2",  80'(tx4.fifo_empty), 80'(1));
    end
    chk("b2b_two_frames", got4, exp4);
    @(negedge CLK);
    chk("b2b_after_busy",   80'(tx4.busy),   80'(0));
    chk("b2b_after_TX_bit", 80'(tx4.TX_bit), 80'(0));
    wait_idle(400);

    // TX_valid held high: 0x01..0x0A, then 0xEE while the FIFO stays full.
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      tx_valid = 1'b1;
      tx_data  = (i < 10) ? 8'(i + 1) : 8'hEE;
      if (i < 10 && tx1.TX_ready) acc++;
      if (i == 11) begin
        chk("full_pop_cycle_ready", 80'(tx1.TX_ready),  80'(0));
        chk("full_pop_cycle_full",  80'(tx1.fifo_full), 80'(1));
      end
      if (i == 12) chk("after_pop_ready", 80'(tx1.TX_ready), 80'(1));
    end
    chk("fill_accepted_count", 80'(acc), 80'(9));
    @(negedge CLK); tx_valid = 1'b0;
    wait_idle(1500);

    // Reset during DATA bit 3 of 0x55 with three more bytes queued.
    @(negedge CLK); tx_valid = 1'b1; tx_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); tx_data = 8'($urandom);
    end
    @(negedge CLK); tx_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_reset_data_bit3", 80'(tx1.TX_bit),     80'(1));
    chk("pre_reset_busy",      80'(tx1.busy),       80'(1));
    chk("pre_reset_queued",    80'(tx1.fifo_empty), 80'(0));
    #2 RST = 1'b1;
    #1 chk_reset_outputs("async_reset");
    @(negedge CLK); #2 RST = 1'b0;
    repeat (40) @(negedge CLK);
    chk("post_reset_dut1_busy", 80'(tx1.busy),   80'(0));
    chk("post_reset_dut4_busy", 80'(tx4.busy),   80'(0));
    chk("post_reset_dut4_bit",  80'(tx4.TX_bit), 80'(0));

    // Random traffic with light, medium and heavy push rates.
    for (int blk = 0; blk < 5; blk++) begin
      case (blk % 3)
        0:       pct = 10;
        1:       pct = 40;
        default: pct = 90;
      endcase
      for (int c = 0; c < 300; c++) begin
        @(negedge CLK);
        tx_valid = ($urandom_range(0, 99) < pct);
        tx_data  = 8'($urandom);
      end
    end
    @(negedge CLK); tx_valid = 1'b0;
    wait_idle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
